// File: rtl/controlo_barreira_if.sv
// Bus between the plate/day access checker side and the barrier gate controller.
// Parameter: CNT_W - width of the admitted-car counter.
// Signals:
//   Pedido, Barreira1, MatrVal, SensorCarro   requester/sensor -> controller
//   Abrir, Fechar, Aberta, Recusado, Ocupado,
//   ContaEntradas                             controller -> requester/motor
// Modports: master (drives requests and the sensor), slave (the controller).
interface controlo_barreira_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             Pedido;
  logic             Barreira1;
  logic             MatrVal;
  logic             SensorCarro;
  logic             Abrir;
  logic             Fechar;
  logic             Aberta;
  logic             Recusado;
  logic             Ocupado;
  logic [CNT_W-1:0] ContaEntradas;

  modport master (
    output Pedido, Barreira1, MatrVal, SensorCarro,
    input  Abrir, Fechar, Aberta, Recusado, Ocupado, ContaEntradas
  );

  modport slave (
    input  Pedido, Barreira1, MatrVal, SensorCarro,
    output Abrir, Fechar, Aberta, Recusado, Ocupado, ContaEntradas
  );
endinterface

// File: rtl/controlo_barreira.sv
// Gate controller downstream of the plate/day access checker.
// Samples the checker verdict on a Pedido pulse and runs the barrier motor through
// an open / wait / close cycle, counting admitted cars and flagging refusals.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - controlo_barreira_if.slave (request/verdict/sensor in, motor/status out)
// Parameters: T_MOTOR (motor pulse length), T_ESPERA (idle cycles before auto-close),
//   CNT_W (admitted-car counter width).
// Optional feature: define REVERSAO_SEGURANCA_EN to reopen the barrier when a vehicle
//   is detected while it is closing.
module controlo_barreira #(
  parameter int unsigned T_MOTOR  = 8,
  parameter int unsigned T_ESPERA = 50,
  parameter int unsigned CNT_W    = 8
) (
  input logic                clk,
  input logic                rst,
  controlo_barreira_if.slave bus
);

  localparam int unsigned TMax   = (T_MOTOR > T_ESPERA) ? T_MOTOR : T_ESPERA;
  localparam int unsigned TimerW = $clog2(TMax + 1);

  localparam logic [TimerW-1:0] MotorLast  = TimerW'(T_MOTOR - 1);
  localparam logic [TimerW-1:0] EsperaLast = TimerW'(T_ESPERA - 1);

  typedef enum logic [1:0] {
    StFechada,
    StAAbrir,
    StAberta,
    StAFechar
  } state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  conta_q, conta_d;
  logic              sensor_q;
  logic              abrir_q, abrir_d;
  logic              fechar_q, fechar_d;
  logic              aberta_q, aberta_d;
  logic              recusado_q, recusado_d;
  logic              ocupado_q, ocupado_d;

  logic passagem;

  // A passage is the car leaving the sensor while the gate is fully open.
  assign passagem = (state_q == StAberta) && sensor_q && !bus.SensorCarro;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    conta_d    = conta_q;
    recusado_d = 1'b0;

    unique case (state_q)
      StFechada: begin
        if (bus.Pedido) begin
          if (!bus.Barreira1 && !bus.MatrVal) begin
            state_d = StAAbrir;
            timer_d = '0;
          end else begin
            recusado_d = 1'b1;
          end
        end
      end

      StAAbrir: begin
        if (timer_q == MotorLast) begin
          state_d = StAberta;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      StAberta: begin
        if (passagem) begin
          state_d = StAFechar;
          timer_d = '0;
          if (conta_q != '1) begin
            conta_d = conta_q + CNT_W'(1);
          end
        end else if (bus.SensorCarro) begin
          // Vehicle under the barrier holds the gate open.
          timer_d = '0;
        end else if (timer_q == EsperaLast) begin
          state_d = StAFechar;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      StAFechar: begin
`ifdef REVERSAO_SEGURANCA_EN
        if (bus.SensorCarro) begin
          state_d = StAAbrir;
          timer_d = '0;
        end else if (timer_q == MotorLast) begin
          state_d = StFechada;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
`else
        if (timer_q == MotorLast) begin
          state_d = StFechada;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
`endif
      end

      default: begin
        state_d = StFechada;
        timer_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registers line up with state_q.
    abrir_d   = (state_d == StAAbrir);
    fechar_d  = (state_d == StAFechar);
    aberta_d  = (state_d == StAberta);
    ocupado_d = (state_d != StFechada);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFechada;
      timer_q    <= '0;
      conta_q    <= '0;
      sensor_q   <= 1'b0;
      abrir_q    <= 1'b0;
      fechar_q   <= 1'b0;
      aberta_q   <= 1'b0;
      recusado_q <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      conta_q    <= conta_d;
      sensor_q   <= bus.SensorCarro;
      abrir_q    <= abrir_d;
      fechar_q   <= fechar_d;
      aberta_q   <= aberta_d;
      recusado_q <= recusado_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign bus.Abrir         = abrir_q;
  assign bus.Fechar        = fechar_q;
  assign bus.Aberta        = aberta_q;
  assign bus.Recusado      = recusado_q;
  assign bus.Ocupado       = ocupado_q;
  assign bus.ContaEntradas = conta_q;

endmodule

// File: tb/tb_controlo_barreira.sv
// Directed bench for controlo_barreira (T_MOTOR=4, T_ESPERA=10, CNT_W=8).
// Each step pushes the expected output vector for the coming edge onto a queue;
// after the edge the vector is popped and compared with the DUT outputs.
module tb_controlo_barreira;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  controlo_barreira_if #(.CNT_W(8)) bus ();

  controlo_barreira #(
    .T_MOTOR (4),
    .T_ESPERA(10),
    .CNT_W   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [12:0] exp_q[$];
  string       tag_q[$];

  // {Abrir, Fechar, Aberta, Recusado, Ocupado, ContaEntradas}
  function automatic logic [12:0] mk(input logic a, input logic f, input logic ab,
                                     input logic r, input logic o, input int c);
    return {a, f, ab, r, o, 8'(c)};
  endfunction

  function automatic logic [12:0] idle_v(input int c);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c);
  endfunction
  function automatic logic [12:0] opening_v(input int c);
    return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c);
  endfunction
  function automatic logic [12:0] open_v(input int c);
    return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, c);
  endfunction
  function automatic logic [12:0] closing_v(input int c);
    return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, c);
  endfunction
  function automatic logic [12:0] refused_v(input int c);
    return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c);
  endfunction

  task automatic check();
    logic [12:0] obs;
    logic [12:0] exp;
    string       tag;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs = {bus.Abrir, bus.Fechar, bus.Aberta, bus.Recusado, bus.Ocupado, bus.ContaEntradas};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b required=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, step past the edge, compare.
  task automatic cyc(input logic p, input logic b1, input logic mv, input logic s,
                     input logic [12:0] exp, input string tag);
    bus.Pedido      = p;
    bus.Barreira1   = b1;
    bus.MatrVal     = mv;
    bus.SensorCarro = s;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    check();
  endtask

  // Full admitted cycle: open, car under sensor for n_sens cycles, leaves, close.
  task automatic passage(input int c_before, input int c_after, input int n_sens);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, opening_v(c_before), "pass_req");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, opening_v(c_before), "pass_abrir");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, open_v(c_before), "pass_aberta");
    for (int i = 0; i < n_sens; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, open_v(c_before), "pass_sensor");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, closing_v(c_after), "pass_edge");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, closing_v(c_after), "pass_fechar");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, idle_v(c_after), "pass_fechada");
  endtask

  initial begin
    bus.Pedido      = 1'b0;
    bus.Barreira1   = 1'b0;
    bus.MatrVal     = 1'b0;
    bus.SensorCarro = 1'b0;
    @(negedge clk);

    // Reset state.
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, idle_v(0), "reset0");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, idle_v(0), "reset_req_ignored");
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, idle_v(0), "idle");

    // Admitted car: 4 Abrir cycles, sensor high 3 cycles, count 1, 4 Fechar cycles.
    passage(0, 1, 3);

    // Refusals: verdict blocked or plate invalid.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, refused_v(1), "refuse_b1");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, idle_v(1), "refuse_b1_end");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, refused_v(1), "refuse_mv");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, idle_v(1), "refuse_mv_end");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, refused_v(1), "refuse_both");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, idle_v(1), "refuse_both_end");

    // Timeout: 10 Aberta cycles with no car, no count; stray Pedido ignored.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, opening_v(1), "to_req");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, opening_v(1), "to_req_busy");
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, opening_v(1), "to_abrir");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, open_v(1), "to_aberta_req");
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, open_v(1), "to_aberta");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, closing_v(1), "to_fechar_req");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, closing_v(1), "to_fechar");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, idle_v(1), "to_fechada");

    // Sensor during closing, on the 2nd Fechar cycle.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, opening_v(1), "rv_req");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, opening_v(1), "rv_abrir");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, open_v(1), "rv_sensor");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, closing_v(2), "rv_edge");
`ifdef REVERSAO_SEGURANCA_EN
    cyc(1'b0, 1'b0, 1'b0, 1'b1, opening_v(2), "rv_reverse");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, opening_v(2), "rv_reabrir");
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, open_v(2), "rv_aberta");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, closing_v(2), "rv_fechar");
`else
    cyc(1'b0, 1'b0, 1'b0, 1'b1, closing_v(2), "rv_no_reverse");
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, closing_v(2), "rv_fechar");
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b0, idle_v(2), "rv_fechada");

    // Drive the counter to saturation, then one more passage must hold 255.
    for (int c = 2; c < 255; c++) passage(c, c + 1, 1);
    passage(255, 255, 2);

    // Reset held 2 cycles mid opening clears everything including the counter.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, opening_v(255), "mid_req");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, opening_v(255), "mid_abrir");
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, idle_v(0), "mid_rst0");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, idle_v(0), "mid_rst1");
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, idle_v(0), "post_rst_idle");
    // A fresh request opens normally, confirming the FSM is back in FECHADA.
    passage(0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
